// File: rtl/tick_div_pkg.sv
// Shared constants and types for the runtime-programmable tick divider bank.
package tick_div_pkg;

  localparam int unsigned TICK_NUM_CH = 4;
  localparam int unsigned TICK_CNT_W  = 28;
  localparam int unsigned TICK_CH_W   = 2;

  localparam logic [TICK_CNT_W-1:0] TICK_DEF_DIV = 28'd4194304;

  typedef logic [TICK_CNT_W-1:0] div_t;

  // A divide value of zero parks the channel once it is committed.
  localparam int unsigned DIV_HALT = 0;

endpackage

// File: rtl/tick_div_channel.sv
// One divider channel: counter, active/shadow divide registers, tick and level outputs.
module tick_div_channel
  import tick_div_pkg::*;
#(
  parameter int unsigned      CNT_W   = TICK_CNT_W,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(TICK_DEF_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             level,
  output logic             pending
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_div;
  logic [CNT_W-1:0] shadow_div;
  logic             running;
  logic             terminal;
  logic             commit;

  // New divide values only take effect on a period boundary or while idle.
  always_comb begin
    running  = en && (active_div != CNT_W'(DIV_HALT));
    terminal = (cnt == active_div - CNT_W'(1));
    commit   = pending && (!running || sync_clr || terminal);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      tick  <= 1'b0;
      level <= 1'b0;
    end else if (!running || sync_clr) begin
      cnt   <= '0;
      tick  <= 1'b0;
      level <= 1'b0;
    end else if (terminal) begin
      cnt   <= '0;
      tick  <= 1'b1;
      level <= ~level;
    end else begin
      cnt   <= cnt + CNT_W'(1);
      tick  <= 1'b0;
    end
  end

  // A write coinciding with a commit keeps pending set for the next boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_div <= DEF_DIV;
      shadow_div <= DEF_DIV;
      pending    <= 1'b0;
    end else begin
      if (commit) begin
        active_div <= shadow_div;
      end
      if (wr) begin
        shadow_div <= wr_div;
        pending    <= 1'b1;
      end else if (commit) begin
        pending    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tick_divider_bank.sv
// Bank of independent programmable clock-enable generators sharing one config port.
module tick_divider_bank
  import tick_div_pkg::*;
#(
  parameter int unsigned      NUM_CH  = TICK_NUM_CH,
  parameter int unsigned      CNT_W   = TICK_CNT_W,
  parameter int unsigned      CH_W    = TICK_CH_W,
  parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(TICK_DEF_DIV)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] wr;

  // Channel selects beyond NUM_CH match no decode and are dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr[i] = cfg_we && (cfg_ch == CH_W'(i));

    tick_div_channel #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .sync_clr (sync_clr),
      .wr       (wr[i]),
      .wr_div   (cfg_div),
      .tick     (tick[i]),
      .level    (level[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: doc/tick_divider_bank.md
Name: tick_divider_bank

Overview:
- Bank of NUM_CH independent, runtime-programmable clock-enable generators, all running off the single system clock.
- Next generation of the free-running power-of-two divider. Each channel takes an arbitrary divide value N, not only 2^k.
- Each channel provides a one-cycle tick (clock enable) and a toggling level output.
- Consumers are the game logic (block-drop slow/fast rate, VGA/animation timing), which must use the ticks as enables, never as clocks.

Parameters:
- NUM_CH, 4, number of channels.
- CNT_W, 28, counter and divide-value width.
- CH_W, 2, channel-select width; must satisfy 2^CH_W >= NUM_CH.
- DEF_DIV, 28'd4194304, divide value loaded into every channel at reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable.
- sync_clr  in  1  synchronous phase-align of all channels.
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_div  in  CNT_W  new divide value N.
- tick  out  NUM_CH  one-cycle pulse every N cycles, registered.
- level  out  NUM_CH  toggles on every tick (period 2N), registered.
- pending  out  NUM_CH  shadow value not yet committed.

Behaviour:
- Reset (async, rst=1):
  - cnt=0, active_div=DEF_DIV, shadow_div=DEF_DIV.
  - tick=0, level=0, pending=0.
- Channel is "running" when en[i]=1 and active_div!=0.
- Running, each clk edge:
  - If cnt==active_div-1: cnt<=0, tick<=1, level<=~level, and a commit occurs if pending.
  - Otherwise: cnt<=cnt+1, tick<=0.
- Tick timing:
  - First tick is seen N cycles after the first running edge.
  - Ticks then repeat every N cycles.
  - N=1: tick stays high continuously and level=clk/2.
- Not running (en=0 or active_div==0):
  - cnt<=0, tick<=0, level<=0.
  - If pending, commit immediately, on the next edge.
- Config write (cfg_we=1):
  - shadow_div[cfg_ch]<=cfg_div and pending[cfg_ch]<=1.
  - cfg_ch >= NUM_CH: write ignored.
- Commit: active_div<=shadow_div, pending<=0.
  - Changes therefore never truncate or stretch the period in progress (glitch-free rate switch).
- Write on the same cycle as that channel's commit:
  - The commit uses the shadow value from before the write.
  - The new value stays pending (pending remains 1).
- Write of N=0 halts the channel at its next commit.
  - Resume by writing a nonzero value; it commits immediately because the channel is not running.
- sync_clr=1:
  - All channels: cnt<=0, tick<=0, level<=0.
  - Pending commits proceed as if not running.
  - Has priority over the terminal-count action in the same cycle.
- Counter arithmetic is modulo 2^CNT_W.
  - cnt never exceeds active_div-1, because a commit only happens at cnt==0 boundaries.
- Reset asserted mid-period: outputs drop asynchronously, and the programmed values are lost (return to DEF_DIV).
- Latency:
  - cfg write to pending visible: 1 cycle.
  - en rise to first tick: N cycles.

Decomposition:
- Package tick_div_pkg:
  - CNT_W/CH_W defaults, DEF_DIV.
  - Typedef div_t (logic [CNT_W-1:0]).
  - Constant DIV_HALT = 0.
- Sub-module tick_div_channel, instantiated NUM_CH times:
  - Holds one cnt/active/shadow/pending/tick/level slice.
  - Inputs: en, sync_clr, wr (decoded cfg_we & cfg_ch==i), wr_div.
- Top: write decode plus generate loop.

Test Plan:
- Reset with DEF_DIV overridden to 4, en=4'b0001 → tick[0] high at cycles 4, 8, 12 after en; level[0] period 8; other channels tick=0.
- Write ch1 N=3 while en[1]=0 → pending[1]=1 for one cycle, then 0. Set en[1]=1 → ticks every 3 cycles.
- ch0 running N=10, write N=2 at cnt=3:
  - pending stays 1 through cnt=9, commits at the terminal count.
  - Next tick 2 cycles later, then ticks every 2 cycles; no short period.
- Write ch0 on the exact terminal-count cycle:
  - Commit takes the old shadow.
  - pending stays 1; new value commits at the following terminal count.
- Write N=0 to ch2 → ch2 halts after its current period (tick/level=0). Write N=5 → resumes with the first tick 5 cycles later.
- Channels at N=3 and N=5 drifting, pulse sync_clr → both cnt=0. First ticks at +3 and +5; coincident ticks every 15 cycles. Assert rst mid-period → all outputs 0 immediately.
